// File: rtl/memory_layer_recall_controller_pkg.sv
// memory_layer_recall_controller_pkg
// Shared types and width helpers for the GAM memory-layer recall path.
//   LEARNING_RECALL_T : mode select shared with the learning controller
//   READY_WAIT_T      : query-side handshake level
//   RECALL_STATE_T    : recall FSM state encoding
//   dist_w()          : squared-distance accumulator width, sized so the sum
//                       of DIM squared element differences can never overflow
//   elem_w()          : element index width (at least one bit)
package memory_layer_recall_controller_pkg;

   typedef enum logic {
      LEARNING = 1'b0,
      RECALL   = 1'b1
   } LEARNING_RECALL_T;

   typedef enum logic {
      WAIT  = 1'b0,
      READY = 1'b1
   } READY_WAIT_T;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } RECALL_STATE_T;

   function automatic int dist_w(input int dim, input int data_w);
      return 2 * data_w + $clog2(dim) + 1;
   endfunction

   function automatic int elem_w(input int dim);
      return (dim > 1) ? $clog2(dim) : 1;
   endfunction

endpackage

// File: rtl/memory_layer_recall_controller_if.sv
// memory_layer_recall_controller_if
// Bundles the three handshakes of the recall controller:
//   query  : in_valid, in_vec, ready_wait
//   memory : mem_rd_en, mem_node_addr, mem_elem_addr -> mem_rd_data, mem_rd_class
//            (read data returns one cycle after the strobe)
//   result : out_valid, out_ready, out_node, out_class, out_dist, out_no_match
// slave  : the recall controller side
// master : the environment (query source, node memory, result consumer)
interface memory_layer_recall_controller_if
   import memory_layer_recall_controller_pkg::*;
#(
   parameter int DIM     = 4,
   parameter int DATA_W  = 8,
   parameter int NODE_W  = 6,
   parameter int CLASS_W = 4
);
   localparam int ELEM_W = elem_w(DIM);
   localparam int DIST_W = dist_w(DIM, DATA_W);

   logic                   in_valid;
   logic [DIM*DATA_W-1:0]  in_vec;
   READY_WAIT_T            ready_wait;

   logic                   mem_rd_en;
   logic [NODE_W-1:0]      mem_node_addr;
   logic [ELEM_W-1:0]      mem_elem_addr;
   logic [DATA_W-1:0]      mem_rd_data;
   logic [CLASS_W-1:0]     mem_rd_class;

   logic                   out_valid;
   logic                   out_ready;
   logic [NODE_W-1:0]      out_node;
   logic [CLASS_W-1:0]     out_class;
   logic [DIST_W-1:0]      out_dist;
   logic                   out_no_match;

   modport slave (
      input  in_valid, in_vec,
      output ready_wait,
      output mem_rd_en, mem_node_addr, mem_elem_addr,
      input  mem_rd_data, mem_rd_class,
      output out_valid,
      input  out_ready,
      output out_node, out_class, out_dist, out_no_match
   );

   modport master (
      output in_valid, in_vec,
      input  ready_wait,
      input  mem_rd_en, mem_node_addr, mem_elem_addr,
      output mem_rd_data, mem_rd_class,
      input  out_valid,
      output out_ready,
      input  out_node, out_class, out_dist, out_no_match
   );

endinterface

// File: rtl/memory_layer_recall_controller_gam_sq_dist_acc.sv
// gam_sq_dist_acc
// Registered squared-difference accumulator. Each valid cycle adds |a-b|^2 to
// the running sum; clear_i restarts the sum with the current term. acc_done_o
// pulses for one cycle after a valid term flagged last_i, while acc_o holds
// the completed sum.
// Ports: clk, reset (sync, active-high), valid_i, clear_i, last_i,
//        a_i, b_i (unsigned DATA_W), acc_o (ACC_W), acc_done_o.
module gam_sq_dist_acc #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 19
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_i,
   input  logic              clear_i,
   input  logic              last_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [ACC_W-1:0]  acc_o,
   output logic              acc_done_o
);

   logic [DATA_W-1:0] diff;
   logic [ACC_W-1:0]  sq;
   logic [ACC_W-1:0]  acc_q;
   logic [ACC_W-1:0]  acc_d;
   logic              done_q;

   always_comb begin
      diff  = (a_i > b_i) ? (a_i - b_i) : (b_i - a_i);
      sq    = ACC_W'(diff) * ACC_W'(diff);
      acc_d = (clear_i ? '0 : acc_q) + sq;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q  <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= valid_i && last_i;
         if (valid_i) begin
            acc_q <= acc_d;
         end
      end
   end

   assign acc_o      = acc_q;
   assign acc_done_o = done_q;

endmodule

// File: rtl/memory_layer_recall_controller.sv
// memory_layer_recall_controller
// Recall-side reader of the GAM memory layer: accepts one query vector, reads
// every stored node element by element, accumulates squared Euclidean
// distance per node and reports the minimum-distance node, its class and the
// distance. Ties keep the lower node index.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   learning_recall     : query accepted only in RECALL (sampled at capture)
//   node_count          : stored nodes, clamped to 2**NODE_W (sampled at capture)
//   recall_threshold    : only with RECALL_THRESHOLD_EN; best_dist above it
//                         flags out_no_match
//   bus (slave modport) : query, memory-read and result handshakes
// Optional build macro: RECALL_THRESHOLD_EN.
//
// state | meaning
// IDLE  | waiting for a query; READY while in RECALL mode
// SCAN  | one memory read per cycle, element-fastest over all nodes
// DRAIN | reads done; final accumulate and compare in flight
// DONE  | result held on out_* until out_ready
module memory_layer_recall_controller
   import memory_layer_recall_controller_pkg::*;
#(
   parameter int DIM     = 4,
   parameter int DATA_W  = 8,
   parameter int NODE_W  = 6,
   parameter int CLASS_W = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  LEARNING_RECALL_T                learning_recall,
   input  logic [NODE_W:0]                 node_count,
`ifdef RECALL_THRESHOLD_EN
   input  logic [dist_w(DIM, DATA_W)-1:0]  recall_threshold,
`endif
   memory_layer_recall_controller_if.slave bus
);

   localparam int ELEM_W = elem_w(DIM);
   localparam int DIST_W = dist_w(DIM, DATA_W);
   localparam int CNT_W  = NODE_W + 1;
   localparam logic [CNT_W-1:0]  MAX_NODES = CNT_W'(1) << NODE_W;
   localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(DIM - 1);

   RECALL_STATE_T         state_q;
   logic [DIM*DATA_W-1:0] x_q;
   logic [CNT_W-1:0]      n_q;
   logic [NODE_W-1:0]     node_q;
   logic [ELEM_W-1:0]     elem_q;
   logic                  rd_en_q;

   // read-return stage: tags for the data arriving on mem_rd_data this cycle
   logic                  pend_q;
   logic [ELEM_W-1:0]     pend_elem_q;
   logic [NODE_W-1:0]     pend_node_q;

   // node whose sum is completing on acc_done
   logic [NODE_W-1:0]     cand_node_q;
   logic [CLASS_W-1:0]    cand_class_q;

   logic [DIST_W-1:0]     best_dist_q;
   logic [NODE_W-1:0]     best_node_q;
   logic [CLASS_W-1:0]    best_class_q;
   logic                  out_valid_q;
   logic                  no_match_q;
`ifdef RECALL_THRESHOLD_EN
   logic [DIST_W-1:0]     thr_q;
`endif

   logic                  accept;
   logic [CNT_W-1:0]      n_clamped;
   logic                  last_issue;
   logic                  pend_last;
   logic [DATA_W-1:0]     x_elem;
   logic [DIST_W-1:0]     acc;
   logic                  acc_done;
   logic                  better;
   logic [DIST_W-1:0]     best_dist_d;
   logic                  no_match_d;

   always_comb begin
      accept     = (state_q == IDLE) && (learning_recall == RECALL) && !reset
                   && bus.in_valid;
      n_clamped  = (node_count > MAX_NODES) ? MAX_NODES : node_count;
      last_issue = ({1'b0, node_q} == (n_q - CNT_W'(1))) && (elem_q == LAST_ELEM);
      pend_last  = pend_q && (pend_elem_q == LAST_ELEM);
      x_elem     = x_q[int'(pend_elem_q) * DATA_W +: DATA_W];
      better     = acc_done && (acc < best_dist_q)
                   && ((state_q == SCAN) || (state_q == DRAIN));
      best_dist_d = better ? acc : best_dist_q;
`ifdef RECALL_THRESHOLD_EN
      no_match_d = (n_q == '0) || (best_dist_d > thr_q);
`else
      no_match_d = (n_q == '0);
`endif
   end

   gam_sq_dist_acc #(
      .DATA_W (DATA_W),
      .ACC_W  (DIST_W)
   ) u_acc (
      .clk        (clk),
      .reset      (reset),
      .valid_i    (pend_q),
      .clear_i    (pend_elem_q == '0),
      .last_i     (pend_elem_q == LAST_ELEM),
      .a_i        (x_elem),
      .b_i        (bus.mem_rd_data),
      .acc_o      (acc),
      .acc_done_o (acc_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         x_q          <= '0;
         n_q          <= '0;
         node_q       <= '0;
         elem_q       <= '0;
         rd_en_q      <= 1'b0;
         pend_q       <= 1'b0;
         pend_elem_q  <= '0;
         pend_node_q  <= '0;
         cand_node_q  <= '0;
         cand_class_q <= '0;
         best_dist_q  <= '1;
         best_node_q  <= '0;
         best_class_q <= '0;
         out_valid_q  <= 1'b0;
         no_match_q   <= 1'b0;
`ifdef RECALL_THRESHOLD_EN
         thr_q        <= '0;
`endif
      end else begin
         pend_q      <= rd_en_q;
         pend_elem_q <= elem_q;
         pend_node_q <= node_q;

         // class is sampled with the node's last element, lined up with acc_done
         if (pend_last) begin
            cand_node_q  <= pend_node_q;
            cand_class_q <= bus.mem_rd_class;
         end

         if (better) begin
            best_dist_q  <= acc;
            best_node_q  <= cand_node_q;
            best_class_q <= cand_class_q;
         end

         case (state_q)
            IDLE: begin
               if (accept) begin
                  x_q          <= bus.in_vec;
                  n_q          <= n_clamped;
                  node_q       <= '0;
                  elem_q       <= '0;
                  best_dist_q  <= '1;
                  best_node_q  <= '0;
                  best_class_q <= '0;
`ifdef RECALL_THRESHOLD_EN
                  thr_q        <= recall_threshold;
`endif
                  if (n_clamped == '0) begin
                     state_q    <= DONE;
                     no_match_q <= 1'b1;
                  end else begin
                     state_q <= SCAN;
                     rd_en_q <= 1'b1;
                  end
               end
            end
            SCAN: begin
               if (last_issue) begin
                  rd_en_q <= 1'b0;
                  state_q <= DRAIN;
               end else if (elem_q == LAST_ELEM) begin
                  elem_q <= '0;
                  node_q <= node_q + NODE_W'(1);
               end else begin
                  elem_q <= elem_q + ELEM_W'(1);
               end
            end
            DRAIN: begin
               // once the return stage empties, acc_done carries the last node
               if (!pend_q) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
                  no_match_q  <= no_match_d;
               end
            end
            DONE: begin
               if (out_valid_q && bus.out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  no_match_q  <= 1'b0;
               end else begin
                  out_valid_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ready_wait    = ((state_q == IDLE) && (learning_recall == RECALL) && !reset)
                              ? READY : WAIT;
   assign bus.mem_rd_en     = rd_en_q;
   assign bus.mem_node_addr = node_q;
   assign bus.mem_elem_addr = elem_q;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_node      = best_node_q;
   assign bus.out_class     = best_class_q;
   assign bus.out_dist      = best_dist_q;
   assign bus.out_no_match  = no_match_q;

endmodule

// File: tb/tb_memory_layer_recall_controller.sv
module tb_memory_layer_recall_controller;
   import memory_layer_recall_controller_pkg::*;

   localparam int DIM     = 4;
   localparam int DATA_W  = 8;
   localparam int NODE_W  = 6;
   localparam int CLASS_W = 4;
   localparam int DIST_W  = 2 * DATA_W + 2 + 1;
   localparam int NMAX    = 64;
   localparam longint DIST_ONES = (64'd1 << DIST_W) - 1;

   logic             clk;
   logic             reset;
   LEARNING_RECALL_T learning_recall;
   logic [NODE_W:0]  node_count;
`ifdef RECALL_THRESHOLD_EN
   logic [DIST_W-1:0] recall_threshold;
`endif

   memory_layer_recall_controller_if #(
      .DIM(DIM), .DATA_W(DATA_W), .NODE_W(NODE_W), .CLASS_W(CLASS_W)
   ) bus ();

   memory_layer_recall_controller #(
      .DIM(DIM), .DATA_W(DATA_W), .NODE_W(NODE_W), .CLASS_W(CLASS_W)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .learning_recall (learning_recall),
      .node_count      (node_count),
`ifdef RECALL_THRESHOLD_EN
      .recall_threshold(recall_threshold),
`endif
      .bus             (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // node memory: registered read, data one cycle after the strobe
   logic [DATA_W-1:0]  w_mem [NMAX][DIM];
   logic [CLASS_W-1:0] c_mem [NMAX];
   int                 x_vec [DIM];
   longint             thr;

   always @(posedge clk) begin
      if (bus.mem_rd_en) begin
         bus.mem_rd_data  <= w_mem[bus.mem_node_addr][bus.mem_elem_addr];
         bus.mem_rd_class <= c_mem[bus.mem_node_addr];
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // reference: brute-force nearest node over the first n stored nodes
   function automatic void ref_model(input int n, output int bn, output int bc,
                                     output longint bd, output bit nm);
      longint d;
      bn = 0; bc = 0; bd = DIST_ONES;
      for (int i = 0; i < n; i++) begin
         d = 0;
         for (int e = 0; e < DIM; e++)
            d += longint'((x_vec[e] - int'(w_mem[i][e])) * (x_vec[e] - int'(w_mem[i][e])));
         if (d < bd) begin
            bd = d; bn = i; bc = int'(c_mem[i]);
         end
      end
      nm = (n == 0);
`ifdef RECALL_THRESHOLD_EN
      if (bd > thr) nm = 1'b1;
`endif
   endfunction

   function automatic logic [DIM*DATA_W-1:0] pack_x();
      logic [DIM*DATA_W-1:0] v;
      for (int e = 0; e < DIM; e++) v[e*DATA_W +: DATA_W] = DATA_W'(x_vec[e]);
      return v;
   endfunction

   task automatic run_query(input string tag, input int nc, input int hold);
      int     n_eff, lat, reads, exp_lat, bn, bc;
      longint bd;
      bit     nm, addr_ok;
      logic [NODE_W-1:0]  s_node;
      logic [CLASS_W-1:0] s_class;
      logic [DIST_W-1:0]  s_dist;
      logic               s_nm;
      n_eff = (nc > NMAX) ? NMAX : nc;
      ref_model(n_eff, bn, bc, bd, nm);
      exp_lat = (n_eff == 0) ? 1 : n_eff * DIM + 2;
      @(negedge clk);
      node_count   = (NODE_W+1)'(nc);
      bus.in_vec   = pack_x();
`ifdef RECALL_THRESHOLD_EN
      recall_threshold = DIST_W'(thr);
`endif
      bus.in_valid = 1'b1;
      chk({tag, ".ready"}, bus.ready_wait, READY);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      node_count = '0;  // must be ignored after capture
      lat = 0; reads = 0; addr_ok = 1'b1;
      while (lat < 400) begin
         @(negedge clk);
         if (bus.out_valid) break;
         if (bus.mem_rd_en) begin
            if (int'(bus.mem_node_addr) != reads / DIM || int'(bus.mem_elem_addr) != reads % DIM)
               addr_ok = 1'b0;
            reads++;
         end
         @(posedge clk);
         lat++;
      end
      chk({tag, ".latency"}, lat, exp_lat);
      chk({tag, ".reads"}, reads, n_eff * DIM);
      chk({tag, ".addr_order"}, addr_ok, 1'b1);
      chk({tag, ".node"}, bus.out_node, bn);
      chk({tag, ".class"}, bus.out_class, bc);
      chk({tag, ".dist"}, bus.out_dist, bd);
      chk({tag, ".no_match"}, bus.out_no_match, nm);
      if (hold > 0) begin
         s_node = bus.out_node; s_class = bus.out_class;
         s_dist = bus.out_dist; s_nm = bus.out_no_match;
         bus.in_valid = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, ".hold_valid"}, bus.out_valid, 1'b1);
            chk({tag, ".hold_wait"}, bus.ready_wait, WAIT);
            chk({tag, ".hold_outs"}, {s_node, s_class, s_dist, s_nm},
                {bus.out_node, bus.out_class, bus.out_dist, bus.out_no_match});
         end
         bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      @(negedge clk);
      chk({tag, ".released"}, bus.out_valid, 1'b0);
      chk({tag, ".ready_after"}, bus.ready_wait, READY);
   endtask

   task automatic load_scenario2();
      for (int e = 0; e < DIM; e++) begin
         w_mem[0][e] = 8'd10; w_mem[1][e] = 8'd0; w_mem[2][e] = 8'd20;
         x_vec[e] = e + 1;
      end
      c_mem[0] = 4'd2; c_mem[1] = 4'd5; c_mem[2] = 4'd7;
   endtask

   initial begin
      int  nn, guard;
      bit  saw_valid, saw_rd;
      reset = 1'b1;
      learning_recall = RECALL;
      node_count = '0;
      thr = DIST_ONES;
`ifdef RECALL_THRESHOLD_EN
      recall_threshold = '1;
`endif
      bus.in_valid = 1'b0; bus.in_vec = '0; bus.out_ready = 1'b0;
      bus.mem_rd_data = '0; bus.mem_rd_class = '0;
      for (int i = 0; i < NMAX; i++) begin
         c_mem[i] = CLASS_W'($urandom);
         for (int e = 0; e < DIM; e++) w_mem[i][e] = DATA_W'($urandom);
      end
      for (int e = 0; e < DIM; e++) x_vec[e] = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset.valid", bus.out_valid, 1'b0);
      chk("reset.rd_en", bus.mem_rd_en, 1'b0);
      chk("reset.wait", bus.ready_wait, WAIT);
      chk("reset.dist", bus.out_dist, DIST_ONES);
      chk("reset.node", bus.out_node, 0);
      chk("reset.no_match", bus.out_no_match, 1'b0);
      reset = 1'b0;
      @(negedge clk);

      // empty memory
      run_query("empty", 0, 0);

      // three-node directed case
      load_scenario2();
      run_query("three", 3, 0);

      // tie between node 0 and node 2, lower index wins
      for (int e = 0; e < DIM; e++) begin
         w_mem[0][e] = 8'd5; w_mem[1][e] = 8'd9; w_mem[2][e] = 8'd5; x_vec[e] = 5;
      end
      run_query("tie", 3, 0);

      // backpressure with a concurrent query attempt
      load_scenario2();
      run_query("backpressure", 3, 5);

      // reset in the middle of a scan
      load_scenario2();
      @(negedge clk);
      node_count = 7'd3; bus.in_vec = pack_x(); bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("abort.rd_en", bus.mem_rd_en, 1'b0);
      chk("abort.valid", bus.out_valid, 1'b0);
      chk("abort.ready", bus.ready_wait, READY);
      saw_valid = 1'b0;
      for (guard = 0; guard < 30; guard++) begin
         @(negedge clk);
         if (bus.out_valid) saw_valid = 1'b1;
      end
      chk("abort.no_result", saw_valid, 1'b0);

      // learning mode: queries ignored
      learning_recall = LEARNING;
      @(negedge clk);
      chk("learn.wait", bus.ready_wait, WAIT);
      bus.in_valid = 1'b1; node_count = 7'd3;
      saw_rd = 1'b0; saw_valid = 1'b0;
      for (guard = 0; guard < 10; guard++) begin
         @(negedge clk);
         if (bus.mem_rd_en) saw_rd = 1'b1;
         if (bus.out_valid) saw_valid = 1'b1;
      end
      bus.in_valid = 1'b0;
      chk("learn.no_read", saw_rd, 1'b0);
      chk("learn.no_result", saw_valid, 1'b0);
      learning_recall = RECALL;
      @(negedge clk);

`ifdef RECALL_THRESHOLD_EN
      load_scenario2();
      thr = 29;
      run_query("thr29", 3, 0);
      thr = 30;
      run_query("thr30", 3, 0);
      thr = DIST_ONES;
`endif

      // node_count above capacity is clamped
      for (int e = 0; e < DIM; e++) x_vec[e] = int'($urandom_range(0, 255));
      run_query("clamp", 100, 0);

      // randomized queries against the reference
      for (int k = 0; k < 8; k++) begin
         nn = int'($urandom_range(1, 12));
         for (int i = 0; i < nn; i++) begin
            c_mem[i] = CLASS_W'($urandom);
            for (int e = 0; e < DIM; e++) w_mem[i][e] = DATA_W'($urandom);
         end
         if ($urandom_range(0, 1) == 1 && nn > 1) begin
            for (int e = 0; e < DIM; e++) w_mem[nn-1][e] = w_mem[0][e];
         end
         for (int e = 0; e < DIM; e++) x_vec[e] = int'($urandom_range(0, 255));
         run_query($sformatf("rand%0d", k), nn, (k == 3) ? 2 : 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/memory_layer_recall_controller.md
Name: memory_layer_recall_controller

Overview:
- Recall-side reader of the GAM memory layer. Learning writes node weight vectors and class labels into memory.
- This block accepts one input vector, scans every stored node through the memory layer read port and accumulates squared Euclidean distance per node.
- Returns the winning (minimum-distance) node index, its class and the distance.
- Active only when learning_recall==RECALL; sits beside the learning controller and shares the same node memory read port through the top-level mux.

Parameters:
- DIM, 4, elements per vector
- DATA_W, 8, unsigned element width
- NODE_W, 6, node index width (max 2**NODE_W nodes)
- CLASS_W, 4, class label width
- localparam DIST_W = 2*DATA_W + $clog2(DIM) + 1, distance width; overflow impossible

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- learning_recall  input  LEARNING_RECALL_T  mode select
- node_count  input  NODE_W+1  number of stored nodes
- in_valid  input  1  input vector valid
- in_vec  input  DIM*DATA_W  query vector; element e at [e*DATA_W +: DATA_W]
- ready_wait  output  READY_WAIT_T  READY = query accepted this cycle if in_valid
- mem_rd_en  output  1  memory read strobe
- mem_node_addr  output  NODE_W  node being read
- mem_elem_addr  output  $clog2(DIM)  element being read
- mem_rd_data  input  DATA_W  weight element; valid 1 cycle after mem_rd_en
- mem_rd_class  input  CLASS_W  class of addressed node; same timing as mem_rd_data
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_node  output  NODE_W  winning node
- out_class  output  CLASS_W  winning class
- out_dist  output  DIST_W  winning squared distance
- out_no_match  output  1  no valid winner

Behaviour:
- Reset and clocking: clk and reset are synchronous, active-high. On reset, the FSM goes to IDLE. All outputs are 0 and ready_wait=WAIT, except out_dist, which is all-ones.
- FSM states: IDLE, SCAN, DRAIN, DONE. The state type is RECALL_STATE_T.
- IDLE:
  - ready_wait=READY only while learning_recall==RECALL; otherwise WAIT.
  - On in_valid && READY (capture edge C):
    - latch in_vec;
    - clear node/elem counters;
    - best_dist = all-ones;
    - go to SCAN, or to DONE if node_count==0.
- SCAN:
  - mem_rd_en=1 every cycle; mem_node_addr/mem_elem_addr step element-fastest: node 0 elements 0..DIM-1, then node 1, and so on.
  - Exactly node_count*DIM reads, issued back-to-back.
  - After the last issue, go to DRAIN.
- Datapath (one cycle behind the issue):
  - diff = |x[e] - mem_rd_data| (unsigned).
  - acc += diff*diff; acc is cleared at element 0 of each node.
  - On a node's last element, compare the final acc with best_dist.
  - Strictly less-than updates best_dist, best_node and best_class, where best_class is the mem_rd_class sampled on that element. Ties keep the lower index.
- DRAIN: mem_rd_en=0; completes the final accumulate/compare, then goes to DONE.
- DONE:
  - out_valid=1, with outputs driven from best_* registers.
  - out_no_match=1 iff node_count==0.
  - Latency:
    - out_valid first high N*DIM+2 cycles after edge C (N = node_count);
    - for N=0, 1 cycle after C.
  - Outputs stay stable while out_valid && !out_ready.
  - On out_valid && out_ready, go to IDLE. ready_wait is WAIT throughout SCAN/DRAIN/DONE, so no back-to-back accept in the same cycle.
- Sampling rules:
  - learning_recall and node_count are sampled only at edge C. Changes mid-scan are ignored.
  - node_count > 2**NODE_W is clamped to 2**NODE_W.
- Reset mid-operation: the FSM is in IDLE and mem_rd_en=0 on the next cycle. Partial results are discarded and out_valid is never asserted for the aborted query.

Optional Feature:
- Macro: RECALL_THRESHOLD_EN.
- Defined:
  - adds input port recall_threshold (DIST_W bits), sampled at edge C;
  - out_no_match=1 also when best_dist > threshold;
  - out_node/out_class/out_dist are still reported.
- Undefined: the port is absent; out_no_match depends only on node_count==0.

Decomposition:
- GAM_package gains:
  - RECALL_STATE_T enum;
  - a DIST_W helper function.
- The existing LEARNING_RECALL_T and READY_WAIT_T are reused.
- One sub-module, gam_sq_dist_acc: registered |a-b|² accumulator with clear/valid/last inputs, outputting acc and acc_done.

Test Plan:
1. node_count=0, RECALL, in_valid → out_valid 1 cycle after capture; out_no_match=1, out_dist=all-ones, out_node=0, out_class=0; mem_rd_en never asserted.
2. Three nodes:
   - stimulus: N=3; w0={10,10,10,10} class 2, w1={0,0,0,0} class 5, w2={20,20,20,20} class 7; in_vec={1,2,3,4};
   - required response: out_node=1, out_class=5, out_dist=30; out_valid 14 cycles after capture; exactly 12 mem_rd_en cycles with correct address order.
3. Tie: nodes 0 and 2 both = in_vec {5,5,5,5}, node 1 distinct → out_node=0, out_dist=0.
4. Backpressure: out_ready low 5 cycles in DONE → outputs constant, ready_wait=WAIT, a concurrent in_valid is not accepted; raise out_ready → IDLE next cycle, READY.
5. Reset and mode gating:
   - reset asserted mid-SCAN of scenario 2 → next cycle mem_rd_en=0, out_valid=0, ready_wait=READY;
   - learning_recall=LEARNING → ready_wait=WAIT and in_valid ignored.
6. With RECALL_THRESHOLD_EN, using scenario 2: threshold=29 → out_no_match=1, out_dist=30; threshold=30 → out_no_match=0.
